// File: rtl/memShare_config_pkg.sv
// ============================================================================
// memShare_config_pkg : shared L1PA / request constants and sequencer types
// Revision: 1.0
// ============================================================================
`default_nettype none

package memShare_config_pkg;

  localparam int L1PA_REGFILE_PAGE_NUM   = 8;
  localparam int L1PA_REGFILE_PAGE_WIDTH = 32;
  localparam int L1PA_REGFILE_ADDR_WIDTH = 3;

  localparam int RQST_ADDR_BITWIDTH = 8;
  localparam int SHARE_GROUP_SIZE   = 4;
  localparam int RQST_MODE_BITWIDTH = 3;

  localparam int SETTLE_CYCLES_DEFAULT = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_RUN    = 2'd3
  } seq_state_e;

endpackage

`default_nettype wire

// File: rtl/memshare_rqst_slot.sv
// ============================================================================
// memshare_rqst_slot : one-entry request register, retired by isGtr_i
// Revision: 1.0
// ============================================================================
`default_nettype none

module memshare_rqst_slot
  import memShare_config_pkg::*;
#(
  parameter int RQST_WIDTH = RQST_ADDR_BITWIDTH * SHARE_GROUP_SIZE,
  parameter int MODE_WIDTH = RQST_MODE_BITWIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic [RQST_WIDTH-1:0] addr_i,
  input  logic [MODE_WIDTH-1:0] mode_i,
  input  logic                  isGtr_i,
  output logic                  valid_o,
  output logic [RQST_WIDTH-1:0] addr_o,
  output logic [MODE_WIDTH-1:0] mode_o,
  output logic                  retire_o
);

  logic                  valid_q, valid_d;
  logic [RQST_WIDTH-1:0] addr_q, addr_d;
  logic [MODE_WIDTH-1:0] mode_q, mode_d;

  always_comb begin
    valid_d  = valid_q;
    addr_d   = addr_q;
    mode_d   = mode_q;
    // isGtr_i only matters while a request is actually outstanding
    retire_o = valid_q & isGtr_i;
    if (retire_o) begin
      valid_d = 1'b0;
    end
    if (load_i) begin
      valid_d = 1'b1;
      addr_d  = addr_i;
      mode_d  = mode_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      mode_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      mode_q  <= mode_d;
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q;
  assign mode_o  = mode_q;

endmodule

`default_nettype wire

// File: rtl/memshare_cfg_sequencer.sv
// ============================================================================
// memshare_cfg_sequencer : loads L1PA pages, settles, then issues requests
// Revision: 1.0
// ============================================================================
`default_nettype none

module memshare_cfg_sequencer
  import memShare_config_pkg::*;
#(
  parameter int PAGE_NUM      = L1PA_REGFILE_PAGE_NUM,
  parameter int PAGE_WIDTH    = L1PA_REGFILE_PAGE_WIDTH,
  parameter int ADDR_WIDTH    = L1PA_REGFILE_ADDR_WIDTH,
  parameter int RQST_WIDTH    = RQST_ADDR_BITWIDTH * SHARE_GROUP_SIZE,
  parameter int MODE_WIDTH    = RQST_MODE_BITWIDTH,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic                  cfg_valid_i,
  input  logic [PAGE_WIDTH-1:0] cfg_data_i,
  output logic                  cfg_ready_o,
  output logic [ADDR_WIDTH-1:0] regType0_waddr_o,
  output logic [PAGE_WIDTH-1:0] regType0_wdata_o,
  output logic                  regType0_we_o,
  output logic                  cfg_done_o,
  input  logic                  rqst_valid_i,
  input  logic [RQST_WIDTH-1:0] rqst_addr_i,
  input  logic [MODE_WIDTH-1:0] modeSet_i,
  output logic                  rqst_ready_o,
  output logic                  rqst_valid_o,
  output logic [RQST_WIDTH-1:0] rqst_addr_o,
  output logic [MODE_WIDTH-1:0] modeSet_o,
  input  logic                  isGtr_i
);

  localparam int SCNT_WIDTH = $clog2(SETTLE_CYCLES + 1);
  localparam logic [ADDR_WIDTH-1:0] C_LAST_PAGE   = ADDR_WIDTH'(PAGE_NUM - 1);
  localparam logic [SCNT_WIDTH-1:0] C_LAST_SETTLE = SCNT_WIDTH'(SETTLE_CYCLES - 1);

  seq_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] page_cnt_q, page_cnt_d;
  logic [SCNT_WIDTH-1:0] settle_cnt_q, settle_cnt_d;
  logic                  stop_pend_q, stop_pend_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [PAGE_WIDTH-1:0] wdata_q, wdata_d;
  logic                  done_q, done_d;
  logic                  cfg_accept, rqst_accept;
  logic                  slot_valid, slot_retire;

  always_comb begin
    state_d      = state_q;
    page_cnt_d   = page_cnt_q;
    settle_cnt_d = settle_cnt_q;
    stop_pend_d  = stop_pend_q;
    we_d         = 1'b0;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    done_d       = 1'b0;

    cfg_ready_o  = (state_q == ST_LOAD);
    // A stop in the same cycle must not let a request slip in behind it
    rqst_ready_o = (state_q == ST_RUN) && !slot_valid && !stop_pend_q && !stop_i;
    cfg_accept   = cfg_ready_o & cfg_valid_i;
    rqst_accept  = rqst_ready_o & rqst_valid_i;

    if (cfg_accept) begin
      we_d    = 1'b1;
      waddr_d = page_cnt_q;
      wdata_d = cfg_data_i;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d    = ST_LOAD;
          page_cnt_d = '0;
        end
      end
      ST_LOAD: begin
        if (cfg_accept) begin
          if (page_cnt_q == C_LAST_PAGE) begin
            state_d      = ST_SETTLE;
            settle_cnt_d = '0;
          end else begin
            page_cnt_d = page_cnt_q + 1'b1;
          end
        end
      end
      ST_SETTLE: begin
        if (settle_cnt_q == C_LAST_SETTLE) begin
          state_d = ST_RUN;
          done_d  = 1'b1;
        end else begin
          settle_cnt_d = settle_cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (slot_valid) begin
          if (stop_i) begin
            stop_pend_d = 1'b1;
          end
          if (slot_retire && (stop_pend_q || stop_i)) begin
            state_d     = ST_IDLE;
            stop_pend_d = 1'b0;
          end
        end else if (stop_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      page_cnt_q   <= '0;
      settle_cnt_q <= '0;
      stop_pend_q  <= 1'b0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      page_cnt_q   <= page_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      stop_pend_q  <= stop_pend_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      done_q       <= done_d;
    end
  end

  memshare_rqst_slot #(
    .RQST_WIDTH (RQST_WIDTH),
    .MODE_WIDTH (MODE_WIDTH)
  ) u_rqst_slot (
    .clk      (sys_clk),
    .rst      (rst),
    .load_i   (rqst_accept),
    .addr_i   (rqst_addr_i),
    .mode_i   (modeSet_i),
    .isGtr_i  (isGtr_i),
    .valid_o  (slot_valid),
    .addr_o   (rqst_addr_o),
    .mode_o   (modeSet_o),
    .retire_o (slot_retire)
  );

  assign rqst_valid_o     = slot_valid;
  assign regType0_we_o    = we_q;
  assign regType0_waddr_o = waddr_q;
  assign regType0_wdata_o = wdata_q;
  assign cfg_done_o       = done_q;

endmodule

`default_nettype wire

// File: tb/tb_memshare_cfg_sequencer.sv
// ============================================================================
// tb_memshare_cfg_sequencer : directed bench for memshare_cfg_sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_memshare_cfg_sequencer;

  localparam int PAGE_NUM      = 5;
  localparam int PAGE_WIDTH    = 8;
  localparam int ADDR_WIDTH    = 3;
  localparam int RQST_WIDTH    = 8;
  localparam int MODE_WIDTH    = 2;
  localparam int SETTLE_CYCLES = 5;

  logic                  sys_clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  start_i = 1'b0;
  logic                  stop_i = 1'b0;
  logic                  cfg_valid_i = 1'b0;
  logic [PAGE_WIDTH-1:0] cfg_data_i = '0;
  logic                  cfg_ready_o;
  logic [ADDR_WIDTH-1:0] regType0_waddr_o;
  logic [PAGE_WIDTH-1:0] regType0_wdata_o;
  logic                  regType0_we_o;
  logic                  cfg_done_o;
  logic                  rqst_valid_i = 1'b0;
  logic [RQST_WIDTH-1:0] rqst_addr_i = '0;
  logic [MODE_WIDTH-1:0] modeSet_i = '0;
  logic                  rqst_ready_o;
  logic                  rqst_valid_o;
  logic [RQST_WIDTH-1:0] rqst_addr_o;
  logic [MODE_WIDTH-1:0] modeSet_o;
  logic                  isGtr_i = 1'b0;

  int vec_cnt = 0;
  int err_cnt = 0;

  memshare_cfg_sequencer #(
    .PAGE_NUM      (PAGE_NUM),
    .PAGE_WIDTH    (PAGE_WIDTH),
    .ADDR_WIDTH    (ADDR_WIDTH),
    .RQST_WIDTH    (RQST_WIDTH),
    .MODE_WIDTH    (MODE_WIDTH),
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) dut (
    .sys_clk          (sys_clk),
    .rst              (rst),
    .start_i          (start_i),
    .stop_i           (stop_i),
    .cfg_valid_i      (cfg_valid_i),
    .cfg_data_i       (cfg_data_i),
    .cfg_ready_o      (cfg_ready_o),
    .regType0_waddr_o (regType0_waddr_o),
    .regType0_wdata_o (regType0_wdata_o),
    .regType0_we_o    (regType0_we_o),
    .cfg_done_o       (cfg_done_o),
    .rqst_valid_i     (rqst_valid_i),
    .rqst_addr_i      (rqst_addr_i),
    .modeSet_i        (modeSet_i),
    .rqst_ready_o     (rqst_ready_o),
    .rqst_valid_o     (rqst_valid_o),
    .rqst_addr_o      (rqst_addr_o),
    .modeSet_o        (modeSet_o),
    .isGtr_i          (isGtr_i)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("load_cfg_ready", 32'(cfg_ready_o), 32'd1);
    chk("load_rqst_ready", 32'(rqst_ready_o), 32'd0);
  endtask

  // Called in the cycle of the last write pulse
  task automatic settle_check(input string tag);
    for (int k = 1; k < SETTLE_CYCLES; k++) begin
      tick();
      chk({tag, "_nodone"}, 32'(cfg_done_o), 32'd0);
      chk({tag, "_settle_we"}, 32'(regType0_we_o), 32'd0);
      chk({tag, "_settle_rdy"}, 32'(cfg_ready_o), 32'd0);
    end
    tick();
    chk({tag, "_done"}, 32'(cfg_done_o), 32'd1);
    chk({tag, "_run_rdy"}, 32'(rqst_ready_o), 32'd1);
    tick();
    chk({tag, "_done_pulse"}, 32'(cfg_done_o), 32'd0);
  endtask

  task automatic issue(input logic [RQST_WIDTH-1:0] a, input logic [MODE_WIDTH-1:0] m,
                       input int hold);
    rqst_valid_i = 1'b1;
    rqst_addr_i  = a;
    modeSet_i    = m;
    chk("issue_ready", 32'(rqst_ready_o), 32'd1);
    tick();
    rqst_valid_i = 1'b0;
    rqst_addr_i  = '0;
    modeSet_i    = '0;
    for (int j = 0; j < hold; j++) begin
      chk("inflight_valid", 32'(rqst_valid_o), 32'd1);
      chk("inflight_addr", 32'(rqst_addr_o), 32'(a));
      chk("inflight_mode", 32'(modeSet_o), 32'(m));
      chk("inflight_ready", 32'(rqst_ready_o), 32'd0);
      if (j == hold - 1) isGtr_i = 1'b1;
      tick();
    end
    isGtr_i = 1'b0;
    chk("retire_valid", 32'(rqst_valid_o), 32'd0);
    chk("retire_ready", 32'(rqst_ready_o), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_cfg_ready", 32'(cfg_ready_o), 32'd0);
    chk("rst_we", 32'(regType0_we_o), 32'd0);
    chk("rst_done", 32'(cfg_done_o), 32'd0);
    chk("rst_rqst_ready", 32'(rqst_ready_o), 32'd0);
    chk("rst_rqst_valid", 32'(rqst_valid_o), 32'd0);
    chk("rst_rqst_addr", 32'(rqst_addr_o), 32'd0);

    // Continuous page stream, data = page index
    do_start();
    cfg_valid_i = 1'b1;
    for (int i = 0; i < PAGE_NUM; i++) begin
      cfg_data_i = PAGE_WIDTH'(i);
      tick();
      chk("cont_we", 32'(regType0_we_o), 32'd1);
      chk("cont_waddr", 32'(regType0_waddr_o), 32'(i));
      chk("cont_wdata", 32'(regType0_wdata_o), 32'(i));
    end
    cfg_valid_i = 1'b0;
    chk("cont_ready_drop", 32'(cfg_ready_o), 32'd0);
    settle_check("cont");

    // Nothing in flight: isGtr_i and start_i have no effect
    isGtr_i = 1'b1;
    start_i = 1'b1;
    tick();
    tick();
    isGtr_i = 1'b0;
    start_i = 1'b0;
    chk("ign_valid", 32'(rqst_valid_o), 32'd0);
    chk("ign_ready", 32'(rqst_ready_o), 32'd1);
    chk("ign_we", 32'(regType0_we_o), 32'd0);
    chk("ign_cfg_ready", 32'(cfg_ready_o), 32'd0);

    // Three back-to-back requests, isGtr_i in the 4th valid cycle
    issue(8'h3C, 2'd1, 4);
    issue(8'hA5, 2'd2, 4);
    issue(8'h5A, 2'd3, 4);

    // Stop while a request is outstanding
    rqst_valid_i = 1'b1;
    rqst_addr_i  = 8'h77;
    modeSet_i    = 2'd2;
    tick();
    rqst_valid_i = 1'b0;
    chk("stop_inflight_valid", 32'(rqst_valid_o), 32'd1);
    stop_i = 1'b1;
    tick();
    stop_i       = 1'b0;
    rqst_valid_i = 1'b1;
    rqst_addr_i  = 8'h99;
    chk("stop_ready_blocked", 32'(rqst_ready_o), 32'd0);
    isGtr_i = 1'b1;
    tick();
    isGtr_i = 1'b0;
    chk("stop_retired", 32'(rqst_valid_o), 32'd0);
    chk("stop_idle_ready", 32'(rqst_ready_o), 32'd0);
    chk("stop_addr_kept", 32'(rqst_addr_o), 32'h77);
    tick();
    rqst_valid_i = 1'b0;
    rqst_addr_i  = '0;
    chk("stop_no_new", 32'(rqst_valid_o), 32'd0);

    // Gapped stream 1,0,1,0: addresses stay contiguous
    do_start();
    for (int p = 0; p < PAGE_NUM; p++) begin
      cfg_valid_i = 1'b1;
      cfg_data_i  = PAGE_WIDTH'(8'hA0 + p);
      tick();
      cfg_valid_i = 1'b0;
      chk("gap_we", 32'(regType0_we_o), 32'd1);
      chk("gap_waddr", 32'(regType0_waddr_o), 32'(p));
      chk("gap_wdata", 32'(regType0_wdata_o), 32'(8'hA0 + p));
      if (p < PAGE_NUM - 1) begin
        tick();
        chk("gap_we_idle", 32'(regType0_we_o), 32'd0);
        chk("gap_still_load", 32'(cfg_ready_o), 32'd1);
      end
    end
    settle_check("gap");

    // Stop with nothing outstanding
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    chk("stop_empty_ready", 32'(rqst_ready_o), 32'd0);

    // Reset in the middle of a load, after page 2
    do_start();
    cfg_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cfg_data_i = PAGE_WIDTH'(8'h10 + i);
      tick();
    end
    chk("midload_waddr", 32'(regType0_waddr_o), 32'd2);
    cfg_valid_i = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_cfg_ready", 32'(cfg_ready_o), 32'd0);
    chk("mrst_we", 32'(regType0_we_o), 32'd0);
    chk("mrst_waddr", 32'(regType0_waddr_o), 32'd0);
    chk("mrst_wdata", 32'(regType0_wdata_o), 32'd0);
    chk("mrst_done", 32'(cfg_done_o), 32'd0);
    chk("mrst_rqst_ready", 32'(rqst_ready_o), 32'd0);
    chk("mrst_rqst_valid", 32'(rqst_valid_o), 32'd0);
    chk("mrst_rqst_addr", 32'(rqst_addr_o), 32'd0);
    chk("mrst_mode", 32'(modeSet_o), 32'd0);

    // Fresh load restarts at address 0
    do_start();
    cfg_valid_i = 1'b1;
    for (int i = 0; i < PAGE_NUM; i++) begin
      cfg_data_i = PAGE_WIDTH'(8'h50 + i);
      tick();
      chk("reload_waddr", 32'(regType0_waddr_o), 32'(i));
      chk("reload_wdata", 32'(regType0_wdata_o), 32'(8'h50 + i));
    end
    cfg_valid_i = 1'b0;
    settle_check("reload");

    // Reset with a request outstanding
    rqst_valid_i = 1'b1;
    rqst_addr_i  = 8'hEE;
    modeSet_i    = 2'd3;
    tick();
    rqst_valid_i = 1'b0;
    chk("rrst_pre_valid", 32'(rqst_valid_o), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rrst_valid", 32'(rqst_valid_o), 32'd0);
    chk("rrst_addr", 32'(rqst_addr_o), 32'd0);
    chk("rrst_mode", 32'(modeSet_o), 32'd0);
    chk("rrst_ready", 32'(rqst_ready_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

`default_nettype wire
